// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register busy scoreboard,
// write-through read bypass and a registered busy-register counter.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   RSaddr_i,
    output logic [NRD*XLEN-1:0] RSdata_o,
    output logic [NRD-1:0]      RSbusy_o,
    input  logic                Issue_i,
    input  logic [AW-1:0]       IssueRD_i,
    output logic                IssueReady_o,
    input  logic                RegWrite_i,
    input  logic [AW-1:0]       RDaddr_i,
    input  logic [XLEN-1:0]     RDdata_i,
    output logic [AW:0]         BusyCnt_o
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            wb, claim, inc, dec;

    assign IssueReady_o = (IssueRD_i == '0) || !busy_q[IssueRD_i] || (RegWrite_i && RDaddr_i == IssueRD_i);
    assign wb    = RegWrite_i && RDaddr_i != '0;
    assign claim = Issue_i && IssueReady_o && IssueRD_i != '0;
    // A claim on a register being retired this cycle keeps it busy, so the count does not move.
    assign inc   = claim && !busy_q[IssueRD_i];
    assign dec   = wb && busy_q[RDaddr_i] && !(claim && IssueRD_i == RDaddr_i);

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = RSaddr_i[k*AW +: AW];
        assign hit = RegWrite_i && RDaddr_i == a;
        assign RSdata_o[k*XLEN +: XLEN] = (a == '0) ? '0 : hit ? RDdata_i : regs_q[a];
        assign RSbusy_o[k] = busy_q[a] && !hit;
    end

    always_comb begin
        busy_d = busy_q;
        if (wb) busy_d[RDaddr_i] = 1'b0;
        if (claim) busy_d[IssueRD_i] = 1'b1;
        cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wb) regs_q[RDaddr_i] <= RDdata_i;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign BusyCnt_o = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table, corner sequences and random
// traffic checked against an array-based reference of the register file.
module tb_regfile_scoreboard;
    localparam int XLEN = 32, NREG = 32, NRD = 2, AW = 5;

    logic            clk = 0, rst = 1;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic            iss, we, ready;
    logic [AW-1:0]   issrd, rd;
    logic [XLEN-1:0] wd;
    logic [AW:0]     cnt;

    int total = 0, bad = 0;

    logic [XLEN-1:0] m_mem [NREG];
    bit              m_busy [NREG];

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk_i(clk), .rst_i(rst), .RSaddr_i(ra), .RSdata_o(rdata), .RSbusy_o(rbusy),
        .Issue_i(iss), .IssueRD_i(issrd), .IssueReady_o(ready),
        .RegWrite_i(we), .RDaddr_i(rd), .RDdata_i(wd), .BusyCnt_o(cnt));

    always #5 clk = ~clk;

    typedef struct {
        bit iss; int issrd; bit we; int rd; logic [31:0] wd; int ra0; int ra1;
        logic [31:0] d0; logic [31:0] d1; logic [1:0] busy; bit rdy; int cnt;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] m_data(input int a);
        if (a == 0) return '0;
        if (we && rd == a) return wd;
        return m_mem[a];
    endfunction

    function automatic bit m_rbusy(input int a);
        return a != 0 && m_busy[a] && !(we && rd == a);
    endfunction

    function automatic bit m_ready();
        return issrd == 0 || !m_busy[issrd] || (we && rd == issrd);
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic check_model(input string tag);
        check({tag, " d0"}, rdata[31:0], m_data(ra[4:0]));
        check({tag, " d1"}, rdata[63:32], m_data(ra[9:5]));
        check({tag, " busy"}, rbusy, {m_rbusy(ra[9:5]), m_rbusy(ra[4:0])});
        check({tag, " ready"}, ready, m_ready());
        check({tag, " cnt"}, cnt, m_cnt());
    endtask

    task automatic tick();
        bit acc;
        acc = iss && m_ready() && issrd != 0;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
        end else begin
            if (we && rd != 0) begin m_mem[rd] = wd; m_busy[rd] = 0; end
            if (acc) m_busy[issrd] = 1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; iss = 0; issrd = 0; we = 0; rd = 0; wd = 0; ra = 0;
    endtask

    initial begin
        //         iss rd  we rd  wd            ra0 ra1  d0           d1     busy rdy cnt
        tbl[0]  = '{0, 0,  0, 0,  32'h0,        5,  0,   32'h0,       32'h0,  2'b00, 1, 0};
        tbl[1]  = '{1, 3,  0, 0,  32'h0,        3,  0,   32'h0,       32'h0,  2'b00, 1, 0};
        tbl[2]  = '{1, 3,  0, 0,  32'h0,        3,  0,   32'h0,       32'h0,  2'b01, 0, 1};
        tbl[3]  = '{0, 0,  0, 0,  32'h0,        3,  0,   32'h0,       32'h0,  2'b01, 1, 1};
        tbl[4]  = '{0, 3,  1, 3,  32'hDEADBEEF, 3,  0,   32'hDEADBEEF,32'h0,  2'b00, 1, 1};
        tbl[5]  = '{0, 0,  0, 0,  32'h0,        3,  0,   32'hDEADBEEF,32'h0,  2'b00, 1, 0};
        tbl[6]  = '{1, 7,  0, 0,  32'h0,        7,  0,   32'h0,       32'h0,  2'b00, 1, 0};
        tbl[7]  = '{1, 7,  1, 7,  32'h12,       7,  0,   32'h12,      32'h0,  2'b00, 1, 1};
        tbl[8]  = '{0, 7,  0, 0,  32'h0,        7,  7,   32'h12,      32'h12, 2'b11, 0, 1};
        tbl[9]  = '{1, 0,  1, 0,  32'hFF,       0,  7,   32'h0,       32'h12, 2'b10, 1, 1};
        tbl[10] = '{0, 0,  0, 0,  32'h0,        0,  0,   32'h0,       32'h0,  2'b00, 1, 1};

        for (int i = 0; i < NREG; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
        idle(); rst = 1;
        tick(); tick();
        rst = 0;

        foreach (tbl[i]) begin
            iss = tbl[i].iss; issrd = AW'(tbl[i].issrd); we = tbl[i].we; rd = AW'(tbl[i].rd);
            wd = tbl[i].wd; ra = {AW'(tbl[i].ra1), AW'(tbl[i].ra0)};
            #1;
            check($sformatf("vec%0d d0", i), rdata[31:0], tbl[i].d0);
            check($sformatf("vec%0d d1", i), rdata[63:32], tbl[i].d1);
            check($sformatf("vec%0d busy", i), rbusy, tbl[i].busy);
            check($sformatf("vec%0d ready", i), ready, tbl[i].rdy);
            check($sformatf("vec%0d cnt", i), cnt, tbl[i].cnt);
            tick();
        end

        // fill x1..x31, then reset with a simultaneous writeback to x4
        idle(); rst = 1; tick(); rst = 0;
        for (int r = 1; r < NREG; r++) begin
            idle(); iss = 1; issrd = AW'(r);
            #1; check($sformatf("fill x%0d ready", r), ready, 1'b1);
            tick();
        end
        idle(); issrd = 5; ra = {AW'(0), AW'(9)};
        #1;
        check("full cnt", cnt, 31);
        check("full ready x5", ready, 1'b0);
        check("full busy x9", rbusy, 2'b01);
        rst = 1; we = 1; rd = 4; wd = 32'hAB; ra = {AW'(4), AW'(4)};
        #1;
        check("rst cycle cnt", cnt, 31);
        check("rst cycle bypass x4", rdata[31:0], 32'hAB);
        tick();
        idle(); ra = {AW'(9), AW'(4)}; issrd = 9;
        #1;
        check("post rst cnt", cnt, 0);
        check("post rst x4", rdata[31:0], 32'h0);
        check("post rst busy", rbusy, 2'b00);
        check("post rst ready", ready, 1'b1);
        // writeback to a register whose claim was discarded by reset
        we = 1; rd = 9; wd = 32'h55;
        tick(); idle(); ra = {AW'(0), AW'(9)};
        #1;
        check("stale wb data", rdata[31:0], 32'h55);
        check("stale wb cnt", cnt, 0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            iss   = $urandom_range(0, 1);
            we    = $urandom_range(0, 1);
            issrd = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            rd    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            wd    = $urandom;
            ra    = {AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9))};
            #1;
            if (!rst) check_model("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, 32, register data width in bits (8..64).
REQ-002 Parameter NREG, 32, number of architectural registers; power of two, 4..64; AW = log2(NREG).
REQ-003 Parameter NRD, 2, number of independent read ports (1..4).
REQ-004 Reset and clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 RSaddr_i  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
REQ-008 RSdata_o  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
REQ-009 RSbusy_o  out  NRD  port k source has a pending (issued, not written back) producer.
REQ-010 Issue_i  in  1  request to claim destination IssueRD_i for an in-flight instruction.
REQ-011 IssueRD_i  in  AW  destination register being claimed.
REQ-012 IssueReady_o  out  1  claim can be accepted this cycle.
REQ-013 RegWrite_i  in  1  writeback strobe.
REQ-014 RDaddr_i  in  AW  writeback register address.
REQ-015 RDdata_i  in  XLEN  writeback data.
REQ-016 BusyCnt_o  out  AW+1  number of registers currently busy.

Function
REQ-017 Storage: NREG x XLEN register array plus NREG-bit busy vector; register 0 reads 0, is never written, never busy.
REQ-018 Read: combinational; RSdata_o[k] = 0 if RSaddr_i[k]==0; else RDdata_i if RegWrite_i and RDaddr_i==RSaddr_i[k] (write-through bypass); else array[RSaddr_i[k]].
REQ-019 RSbusy_o[k] = busy[RSaddr_i[k]] AND NOT (RegWrite_i AND RDaddr_i==RSaddr_i[k]); always 0 for address 0.
REQ-020 IssueReady_o = (IssueRD_i==0) OR NOT busy[IssueRD_i] OR (RegWrite_i AND RDaddr_i==IssueRD_i); combinational, no dependence on Issue_i.
REQ-021 Claim accepted when Issue_i AND IssueReady_o; accepted nonzero IssueRD_i sets busy bit at next edge; IssueRD_i==0 accepted with no state change.
REQ-022 Issue_i with IssueReady_o=0: no state change (WAW stall); requester holds Issue_i/IssueRD_i until ready.
REQ-023 Writeback: RegWrite_i with RDaddr_i!=0 writes RDdata_i to array and clears busy[RDaddr_i] at next edge; RDaddr_i==0 ignored.
REQ-024 Writeback to a non-busy register is legal: data written, busy stays 0.
REQ-025 Same-cycle accepted claim and writeback to same register: data written, busy ends SET (new owner wins).
REQ-026 Same-cycle claim and writeback to different registers: both take effect independently.
REQ-027 BusyCnt_o is a registered counter: +1 on accepted nonzero claim to a non-busy reg, -1 on writeback clearing a busy reg, net 0 when both or in REQ-025 case; never exceeds NREG-1, never underflows; equals popcount of busy vector every cycle.
REQ-028 No latency beyond one edge: state written at edge N visible on reads in cycle N+1; same-cycle visibility only via REQ-018/019 bypass.

Reset
REQ-029 rst_i high at an edge clears every array entry to 0, busy vector to 0, BusyCnt_o to 0; takes priority over simultaneous claim/writeback.
REQ-030 During reset cycle outputs remain combinational on pre-reset state; after the reset edge RSdata_o=0, RSbusy_o=0, IssueReady_o=1, BusyCnt_o=0.
REQ-031 Reset asserted mid-operation discards all pending claims; later writebacks to those registers are treated per REQ-024.

Verification
REQ-032 Reset then read x5, x0 on ports 0/1 -> RSdata_o=0/0, RSbusy_o=00, BusyCnt_o=0.
REQ-033 Claim x3; next cycle read x3 -> RSbusy_o[0]=1, BusyCnt_o=1; claim x3 again -> IssueReady_o=0, state unchanged.
REQ-034 Writeback x3=0xDEADBEEF while reading x3 same cycle -> RSdata_o=0xDEADBEEF, RSbusy_o[0]=0, IssueReady_o=1; next cycle BusyCnt_o=0.
REQ-035 Claim x7 and writeback x7=0x12 same cycle (x7 busy) -> next cycle x7 reads 0x12, busy=1, BusyCnt_o unchanged.
REQ-036 Claim x0 and writeback x0=0xFF -> x0 reads 0, never busy, BusyCnt_o unchanged.
REQ-037 Claim x1..x31 (NREG=32), then rst_i with simultaneous writeback x4 -> BusyCnt_o 31 before, 0 after; x4 reads 0.
